// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: drives a 3-digit common-anode seven-segment display
// from a BCD value (hundreds/tens/ones). The display is time-multiplexed.
// Incoming values are double-buffered so the shown digits change only at
// frame boundaries. Each digit slot starts with an all-anodes-off blanking
// interval. Leading-zero suppression is optional.
//
// Handshake: value_valid is a one-cycle strobe with no ready. A write is
// accepted in every cycle; if several writes arrive within one frame, the
// last one is the value shown in the next frame.
module bcd_display_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       value_valid,
  input  logic [1:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       lz_blank,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  // Digit index is a small scan FSM: ones -> tens -> hundreds -> ones.
  typedef enum logic [1:0] {
    DIG_ONES     = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } digit_t;

  digit_t        digit, digit_next;
  logic [CW-1:0] cnt;
  logic          wrap, boundary, in_blank;

  logic [1:0] pend_h, disp_h;
  logic [3:0] pend_t, pend_o, disp_t, disp_o;
  logic       pend_flag;

  logic [2:0] an_d;
  logic [6:0] seg_d;

  assign wrap     = (cnt == SLOT_LAST);
  assign boundary = wrap && (digit == DIG_HUNDREDS);
  assign in_blank = (cnt < BLANK_END);

  // Active-low segment decode {g,f,e,d,c,b,a}. Non-BCD codes go dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // Slot counter: 0..REFRESH_DIV-1, then wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (wrap) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  // Digit index state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) digit <= DIG_ONES;
    else digit <= digit_next;
  end

  // Digit index next state: advance on every slot wrap.
  always_comb begin
    digit_next = digit;
    if (wrap) begin
      case (digit)
        DIG_ONES: digit_next = DIG_TENS;
        DIG_TENS: digit_next = DIG_HUNDREDS;
        default:  digit_next = DIG_ONES;
      endcase
    end
  end

  // Double buffer. The transfer at a boundary uses the old pending
  // content; a write in the same cycle lands in pending and stays flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_h    <= '0;
      pend_t    <= '0;
      pend_o    <= '0;
      pend_flag <= 1'b0;
      disp_h    <= '0;
      disp_t    <= '0;
      disp_o    <= '0;
    end else begin
      if (boundary && pend_flag) begin
        disp_h    <= pend_h;
        disp_t    <= pend_t;
        disp_o    <= pend_o;
        pend_flag <= 1'b0;
      end
      if (value_valid) begin
        pend_h    <= hundreds;
        pend_t    <= tens;
        pend_o    <= ones;
        pend_flag <= 1'b1;
      end
    end
  end

  // Anode/segment selection for the current slot. Blanking and suppression
  // keep every anode high and all segments dark.
  always_comb begin
    an_d  = 3'b111;
    seg_d = 7'h7F;
    if (!in_blank) begin
      case (digit)
        DIG_ONES: begin
          an_d  = 3'b110;
          seg_d = seg_decode(disp_o);
        end
        DIG_TENS: begin
          if (!(lz_blank && disp_h == 2'd0 && disp_t == 4'd0)) begin
            an_d  = 3'b101;
            seg_d = seg_decode(disp_t);
          end
        end
        DIG_HUNDREDS: begin
          if (!(lz_blank && disp_h == 2'd0)) begin
            an_d  = 3'b011;
            seg_d = (disp_h == 2'd3) ? 7'h7F : seg_decode({2'b00, disp_h});
          end
        end
        default: begin
          an_d  = 3'b111;
          seg_d = 7'h7F;
        end
      endcase
    end
  end

  // Registered outputs. frame_done marks the cycle after a boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 3'b111;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner. A reference model computes the expected
// registered outputs from the cycle number since reset. It pushes one
// expectation per clock into exp_q. A monitor pops and compares on the
// falling edge.
module tb_bcd_display_scanner;

  localparam int RD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = 3 * RD;

  logic       clk;
  logic       rst;
  logic       value_valid;
  logic [1:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       lz_blank;
  logic [2:0] an;
  logic [6:0] seg;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_q[$];

  bcd_display_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk(clk),
    .rst(rst),
    .value_valid(value_valid),
    .hundreds(hundreds),
    .tens(tens),
    .ones(ones),
    .lz_blank(lz_blank),
    .an(an),
    .seg(seg),
    .frame_done(frame_done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int         t_m;
  logic [1:0] m_disp_h, m_pend_h;
  logic [3:0] m_disp_t, m_disp_o, m_pend_t, m_pend_o;
  bit         m_flag;
  logic [6:0] lut [0:15];

  initial begin
    for (int i = 0; i < 16; i++) lut[i] = 7'h7F;
    lut[0] = 7'h40; lut[1] = 7'h79; lut[2] = 7'h24; lut[3] = 7'h30;
    lut[4] = 7'h19; lut[5] = 7'h12; lut[6] = 7'h02; lut[7] = 7'h78;
    lut[8] = 7'h00; lut[9] = 7'h10;
  end

  // Model: cycle t shows slot (t/RD)%3 at position t%RD. The registered
  // outputs after the edge reflect cycle t.
  initial begin
    t_m = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        t_m = 0;
        m_disp_h = 0; m_disp_t = 0; m_disp_o = 0;
        m_pend_h = 0; m_pend_t = 0; m_pend_o = 0;
        m_flag = 0;
        exp_q.push_back({3'b111, 7'h7F, 1'b0});
      end else begin
        int pos, slot;
        bit bnd;
        logic [2:0] e_an;
        logic [6:0] e_seg;
        pos  = t_m % RD;
        slot = (t_m / RD) % 3;
        bnd  = (t_m % FRAME) == FRAME - 1;
        e_an = 3'b111;
        e_seg = 7'h7F;
        if (pos >= BL) begin
          if (slot == 0) begin
            e_an = 3'b110;
            e_seg = lut[m_disp_o];
          end else if (slot == 1) begin
            if (!(lz_blank && m_disp_h == 0 && m_disp_t == 0)) begin
              e_an = 3'b101;
              e_seg = lut[m_disp_t];
            end
          end else begin
            if (!(lz_blank && m_disp_h == 0)) begin
              e_an = 3'b011;
              e_seg = (m_disp_h <= 2) ? lut[{2'b00, m_disp_h}] : 7'h7F;
            end
          end
        end
        exp_q.push_back({e_an, e_seg, bnd});
        if (bnd && m_flag) begin
          m_disp_h = m_pend_h; m_disp_t = m_pend_t; m_disp_o = m_pend_o;
          m_flag = 0;
        end
        if (value_valid) begin
          m_pend_h = hundreds; m_pend_t = tens; m_pend_o = ones;
          m_flag = 1;
        end
        t_m++;
      end
    end
  end

  // Scoreboard monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [10:0] e;
      e = exp_q.pop_front();
      total++;
      if ({an, seg, frame_done} !== e) begin
        bad++;
        $display("FAIL scan t=%0d: got an=%b seg=%h fd=%b, expected an=%b seg=%h fd=%b",
                 t_m, an, seg, frame_done, e[10:8], e[7:1], e[0]);
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_val(input logic [1:0] h, input logic [3:0] tv, input logic [3:0] o);
    @(negedge clk);
    value_valid = 1'b1;
    hundreds = h; tens = tv; ones = o;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  // Pulse value_valid during the cycle whose frame position is pos.
  task automatic write_at(input int pos, input logic [1:0] h, input logic [3:0] tv,
                          input logic [3:0] o);
    bit hit;
    hit = 0;
    for (int i = 0; i < 4 * FRAME && !hit; i++) begin
      @(negedge clk);
      if ((t_m % FRAME) == pos) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL align: got no frame position %0d, required one within %0d cycles", pos, 4 * FRAME);
    end
    value_valid = 1'b1;
    hundreds = h; tens = tv; ones = o;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic async_reset_mid_tens();
    bit hit;
    hit = 0;
    for (int i = 0; i < 4 * FRAME && !hit; i++) begin
      @(negedge clk);
      if (an == 3'b101) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL rst_align: got no an=101 within %0d cycles, required one", 4 * FRAME);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({an, seg, frame_done} !== {3'b111, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL async_rst: got an=%b seg=%h fd=%b, required an=111 seg=7f fd=0",
               an, seg, frame_done);
    end
    tick(3);
    rst = 1'b0;
  endtask

  // Main stimulus
  initial begin
    rst = 1'b1;
    value_valid = 1'b0;
    hundreds = 0; tens = 0; ones = 0;
    lz_blank = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(30);

    // 2/5/5 written mid-frame, lz off
    write_val(2'd2, 4'd5, 4'd5);
    tick(2 * FRAME);

    // last write wins within one frame
    write_at(3, 2'd1, 4'd2, 4'd3);
    write_at(14, 2'd0, 4'd0, 4'd7);
    tick(FRAME + 4);

    // write exactly on the boundary cycle
    write_at(FRAME - 1, 2'd1, 4'd4, 4'd2);
    tick(2 * FRAME);

    // leading-zero suppression
    lz_blank = 1'b1;
    write_val(2'd0, 4'd0, 4'd7);
    tick(2 * FRAME);
    write_val(2'd0, 4'd1, 4'd0);
    tick(2 * FRAME);

    // illegal digits
    lz_blank = 1'b0;
    write_val(2'd3, 4'd12, 4'd4);
    tick(2 * FRAME);

    // randomized writes and lz toggling
    for (int k = 0; k < 14; k++) begin
      tick($urandom_range(0, 30));
      lz_blank = 1'($urandom_range(0, 1));
      write_val(2'($urandom_range(0, 3)), 4'($urandom_range(0, 11)),
                4'($urandom_range(0, 9)));
    end
    tick(2 * FRAME);

    // async reset while tens anode is driven, then restart
    lz_blank = 1'b0;
    write_val(2'd1, 4'd6, 4'd8);
    tick(FRAME);
    async_reset_mid_tens();
    tick(FRAME + 6);

    @(negedge clk);
    total++;
    if (exp_q.size() > 1) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, required at most 1", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
